// File: rtl/prf_free_list.sv
// Free list of physical register tags: a circular FIFO of unallocated tags plus
// a per-tag busy bitmap so that releasing a tag that is not busy is flagged.
module prf_free_list #(
  parameter int NUM_PRF  = 16,
  parameter int NUM_ARCH = 8,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop,
  input  logic             alloc_req,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             full_PRF,
  input  logic             rel_valid,
  input  logic [TAG_W-1:0] rel_tag,
  output logic [TAG_W-1:0] free_count,
  output logic             err
);

  localparam int DEPTH = NUM_PRF - NUM_ARCH;
  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0]   fifo_q [DEPTH];
  logic [TAG_W-1:0]   fifo_d [DEPTH];
  logic [NUM_PRF-1:0] busy_q, busy_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [TAG_W-1:0]   count_q, count_d;
  logic               err_q, err_d;

  logic               grant;
  logic               rel_legal;
  logic [TAG_W-1:0]   head_tag;

  assign head_tag   = fifo_q[head_q];
  assign alloc_tag  = head_tag;
  assign full_PRF   = (count_q == '0);
  assign free_count = count_q;
  assign err        = err_q;

  always_comb begin
    grant     = alloc_req & ~full_PRF & ~stop;
    // A tag is only busy once granted, so the same-cycle collision term is a guard.
    rel_legal = rel_valid & busy_q[rel_tag] & (count_q < TAG_W'(DEPTH))
                & ~(grant & (head_tag == rel_tag));

    fifo_d  = fifo_q;
    busy_d  = busy_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;

    if (grant) begin
      head_d           = head_q + PTR_W'(1);
      busy_d[head_tag] = 1'b1;
    end

    if (rel_legal) begin
      fifo_d[tail_q]  = rel_tag;
      tail_d          = tail_q + PTR_W'(1);
      busy_d[rel_tag] = 1'b0;
    end else if (rel_valid) begin
      err_d = 1'b1;
    end

    case ({grant, rel_legal})
      2'b10:   count_d = count_q - TAG_W'(1);
      2'b01:   count_d = count_q + TAG_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= TAG_W'(NUM_ARCH + i);
      end
      for (int t = 0; t < NUM_PRF; t++) begin
        busy_q[t] <= (t < NUM_ARCH);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= TAG_W'(DEPTH);
      err_q   <= 1'b0;
    end else begin
      fifo_q  <= fifo_d;
      busy_q  <= busy_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_prf_free_list.sv
// Directed plus random stimulus against a queue-based free-list scoreboard.
module tb_prf_free_list;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stop;
  logic       alloc_req;
  logic [3:0] alloc_tag;
  logic       full_PRF;
  logic       rel_valid;
  logic [3:0] rel_tag;
  logic [3:0] free_count;
  logic       err;

  int passes = 0;
  int checks = 0;

  logic [3:0] free_q [$];
  logic       mbusy [16];
  logic       merr;

  prf_free_list dut (
    .clk        (clk),
    .rst        (rst_n),
    .stop       (stop),
    .alloc_req  (alloc_req),
    .alloc_tag  (alloc_tag),
    .full_PRF   (full_PRF),
    .rel_valid  (rel_valid),
    .rel_tag    (rel_tag),
    .free_count (free_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    free_q.delete();
    for (int i = 0; i < 8; i++) free_q.push_back(4'(8 + i));
    for (int t = 0; t < 16; t++) mbusy[t] = (t < 8);
    merr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(free_count), 32'(free_q.size()));
    chk({tag, "_full"}, 32'(full_PRF), 32'(free_q.size() == 0));
    chk({tag, "_err"}, 32'(err), 32'(merr));
    if (free_q.size() > 0) chk({tag, "_tag"}, 32'(alloc_tag), 32'(free_q[0]));
  endtask

  // One clock: drive, check pre-edge outputs, update the scoreboard, check post-edge.
  task automatic cycle(input string tag, input logic a, input logic s,
                       input logic rv, input logic [3:0] rt);
    logic       g, legal;
    logic [3:0] head;
    alloc_req = a;
    stop      = s;
    rel_valid = rv;
    rel_tag   = rt;
    #1;
    chk({tag, "_pre_full"}, 32'(full_PRF), 32'(free_q.size() == 0));
    g     = a && (free_q.size() > 0) && !s;
    head  = (free_q.size() > 0) ? free_q[0] : 4'h0;
    legal = rv && mbusy[rt] && (free_q.size() < 8) && !(g && head == rt);
    if (g) begin
      chk({tag, "_grant_tag"}, 32'(alloc_tag), 32'(head));
      void'(free_q.pop_front());
      mbusy[head] = 1'b1;
    end
    if (legal) begin
      free_q.push_back(rt);
      mbusy[rt] = 1'b0;
    end else if (rv) begin
      merr = 1'b1;
    end
    @(posedge clk);
    #1;
    alloc_req = 1'b0;
    rel_valid = 1'b0;
    stop      = 1'b0;
    check_state(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    stop      = 1'b0;
    alloc_req = 1'b0;
    rel_valid = 1'b0;
    rel_tag   = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tag", 32'(alloc_tag), 32'd8);
    chk("reset_count", 32'(free_count), 32'd8);
    chk("reset_full", 32'(full_PRF), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) cycle("alloc", 1'b1, 1'b0, 1'b0, 4'h0);
    chk("drain_count", 32'(free_count), 32'd0);
    chk("drain_full", 32'(full_PRF), 32'd1);
    cycle("alloc_full", 1'b1, 1'b0, 1'b0, 4'h0);

    cycle("rel3_at_full", 1'b0, 1'b0, 1'b1, 4'd3);
    chk("rel3_tag", 32'(alloc_tag), 32'd3);
    chk("rel3_count", 32'(free_count), 32'd1);

    cycle("rel0", 1'b0, 1'b0, 1'b1, 4'd0);
    cycle("rel1", 1'b0, 1'b0, 1'b1, 4'd1);
    cycle("rel2", 1'b0, 1'b0, 1'b1, 4'd2);
    cycle("both", 1'b1, 1'b0, 1'b1, 4'd9);
    chk("both_count", 32'(free_count), 32'd4);
    chk("both_head", 32'(alloc_tag), 32'd0);
    for (int i = 0; i < 4; i++) cycle("tail_drain", 1'b1, 1'b0, 1'b0, 4'h0);

    cycle("rel12", 1'b0, 1'b0, 1'b1, 4'd12);
    cycle("rel12_again", 1'b0, 1'b0, 1'b1, 4'd12);
    chk("err_sticky", 32'(err), 32'd1);
    cycle("rel13_after_err", 1'b0, 1'b0, 1'b1, 4'd13);
    chk("rel13_count", 32'(free_count), 32'd2);

    cycle("stop1", 1'b1, 1'b1, 1'b0, 4'h0);
    cycle("stop2", 1'b1, 1'b1, 1'b1, 4'd14);
    cycle("stop3", 1'b1, 1'b1, 1'b0, 4'h0);
    chk("stop_count", 32'(free_count), 32'd3);
    chk("stop_head", 32'(alloc_tag), 32'd12);

    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_tag", 32'(alloc_tag), 32'd8);
    chk("async_rst_count", 32'(free_count), 32'd8);
    chk("async_rst_full", 32'(full_PRF), 32'd0);
    chk("async_rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    cycle("rel_at_depth", 1'b0, 1'b0, 1'b1, 4'd0);
    chk("depth_err", 32'(err), 32'd1);

    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
